// File: rtl/mod_writeback.sv
// ---------------------------------------------------------------------------
// mod_writeback -- retirement / writeback stage
//
// Accepts one retiring instruction per cycle from execute (ex_valid/wb_ready
// handshake) and performs its register-file write one cycle later through a
// single registered write port. Opcode 247 (IMUL with a 128-bit result)
// needs two writes (RAX then RDX), so the stage spends one extra cycle in HI
// with wb_ready low. The final instruction (sim_end_in) parks the stage in
// HALT after its last write; only reset leaves HALT.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ex_valid / wb_ready handshake; transfer when both are high
//   opcode, dep,        instruction info used for destination select
//   regByte, rmByte
//   no_dest             instruction writes no register
//   alu_result,         low / high (RDX) result
//   alu_ext_result
//   rip_in              next-PC of the instruction
//   flags_we, rflags_in flag update request and value
//   sim_end_in          instruction is the last one
//   rf_we/rf_waddr/     register-file write port (registered)
//   rf_wdata
//   rflags_seq          committed RFLAGS
//   rip_commit          rip of last retired instruction
//   sim_done            high once the final instruction has retired
//   retired_count       (only with WB_RETIRE_COUNT_EN) retired instructions
//
// Configuration macro: WB_RETIRE_COUNT_EN adds the retired_count output.
// ---------------------------------------------------------------------------
module mod_writeback #(
    parameter int NREGS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    output logic        wb_ready,
    input  logic [7:0]  opcode,
    input  logic [1:0]  dep,
    input  logic [3:0]  regByte,
    input  logic [3:0]  rmByte,
    input  logic        no_dest,
    input  logic [63:0] alu_result,
    input  logic [63:0] alu_ext_result,
    input  logic [63:0] rip_in,
    input  logic        flags_we,
    input  logic [63:0] rflags_in,
    input  logic        sim_end_in,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [63:0] rf_wdata,
    output logic [63:0] rflags_seq,
    output logic [63:0] rip_commit,
    output logic        sim_done
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [63:0] retired_count
`endif
);

    localparam logic [7:0] OP_MUL    = 8'd247;
    localparam logic [7:0] OP_RAXDST = 8'd13;
    localparam logic [3:0] REG_RAX   = 4'd0;
    localparam logic [3:0] REG_RDX   = 4'd2;

    // RFLAGS reserved bits: bit 1 always reads 1, bits 3 and 5 always read 0.
    localparam logic [63:0] FLAGS_SET_MASK = 64'h0000_0000_0000_0002;
    localparam logic [63:0] FLAGS_CLR_MASK = 64'h0000_0000_0000_0028;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Operands held for the second (RDX) write of opcode 247.
    logic [63:0] ext_reg;
    logic        hi_we_reg;
    logic        hi_end_reg;

    logic        transfer;
    logic        is_mul;
    logic        no_write_op;
    logic        dest_in_range;
    logic        wr_en;
    logic [3:0]  dest;
    logic [63:0] flags_fixed;

    assign wb_ready = (state_reg == IDLE);
    assign transfer = ex_valid && wb_ready;
    assign is_mul   = (opcode == OP_MUL);

    // Compares, conditional jumps and stores retire without a register write.
    assign no_write_op = (opcode == 8'd116) || (opcode == 8'd125) || (opcode == 8'd141);

    always_comb begin
        dest = (dep == 2'd2) ? regByte : rmByte;
        if (opcode == OP_RAXDST || is_mul) begin
            dest = REG_RAX;
        end
    end

    // Indices beyond the architectural register count are never written.
    assign dest_in_range = (int'({28'd0, dest}) < NREGS);
    assign wr_en         = !no_dest && !no_write_op && dest_in_range;
    assign flags_fixed   = (rflags_in | FLAGS_SET_MASK) & ~FLAGS_CLR_MASK;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (ex_valid) begin
                    if (is_mul) begin
                        state_next = HI;
                    end else if (sim_end_in) begin
                        state_next = HALT;
                    end
                end
            end
            HI:      state_next = hi_end_reg ? HALT : IDLE;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            rf_we      <= 1'b0;
            rf_waddr   <= 4'd0;
            rf_wdata   <= 64'd0;
            rflags_seq <= 64'h2;
            rip_commit <= 64'd0;
            sim_done   <= 1'b0;
            ext_reg    <= 64'd0;
            hi_we_reg  <= 1'b0;
            hi_end_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rf_we     <= 1'b0;
            if (transfer) begin
                rf_we      <= wr_en;
                rf_waddr   <= dest;
                rf_wdata   <= alu_result;
                rip_commit <= rip_in;
                if (flags_we) begin
                    rflags_seq <= flags_fixed;
                end
                ext_reg    <= alu_ext_result;
                hi_we_reg  <= !no_dest;
                hi_end_reg <= sim_end_in;
                // A two-write instruction signals completion from HI instead.
                if (sim_end_in && !is_mul) begin
                    sim_done <= 1'b1;
                end
            end else if (state_reg == HI) begin
                rf_we    <= hi_we_reg;
                rf_waddr <= REG_RDX;
                rf_wdata <= ext_reg;
                if (hi_end_reg) begin
                    sim_done <= 1'b1;
                end
            end
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    // Counts at each instruction's final writeback cycle, so 247 counts once.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_count <= 64'd0;
        end else if ((transfer && !is_mul) || (state_reg == HI)) begin
            retired_count <= retired_count + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mod_writeback.sv
// ---------------------------------------------------------------------------
// tb_mod_writeback -- scoreboard bench for mod_writeback
//
// The stimulus process drives one cycle at a time and, from the instruction
// rules, writes the expected outputs of future cycles into a cycle-indexed
// timeline and pushes every expected register write into a queue. A monitor
// on the falling edge compares the timeline entry for the current cycle and
// pops the write queue whenever the DUT asserts rf_we.
// ---------------------------------------------------------------------------
module tb_mod_writeback;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ex_valid = 1'b0;
    logic        wb_ready;
    logic [7:0]  opcode = 8'd0;
    logic [1:0]  dep = 2'd0;
    logic [3:0]  regByte = 4'd0;
    logic [3:0]  rmByte = 4'd0;
    logic        no_dest = 1'b0;
    logic [63:0] alu_result = 64'd0;
    logic [63:0] alu_ext_result = 64'd0;
    logic [63:0] rip_in = 64'd0;
    logic        flags_we = 1'b0;
    logic [63:0] rflags_in = 64'd0;
    logic        sim_end_in = 1'b0;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [63:0] rflags_seq;
    logic [63:0] rip_commit;
    logic        sim_done;
`ifdef WB_RETIRE_COUNT_EN
    logic [63:0] retired_count;
`endif

    mod_writeback #(.NREGS(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .wb_ready       (wb_ready),
        .opcode         (opcode),
        .dep            (dep),
        .regByte        (regByte),
        .rmByte         (rmByte),
        .no_dest        (no_dest),
        .alu_result     (alu_result),
        .alu_ext_result (alu_ext_result),
        .rip_in         (rip_in),
        .flags_we       (flags_we),
        .rflags_in      (rflags_in),
        .sim_end_in     (sim_end_in),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rflags_seq     (rflags_seq),
        .rip_commit     (rip_commit),
        .sim_done       (sim_done)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .retired_count  (retired_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          we;
        bit          chk_ad;
        logic [3:0]  addr;
        logic [63:0] data;
        bit          ready;
        logic [63:0] flags;
        logic [63:0] rip;
        bit          done;
        logic [63:0] cnt;
    } exp_t;

    typedef struct {
        int          cyc;
        logic [3:0]  addr;
        logic [63:0] data;
    } wr_t;

    exp_t tl [MAXC];
    wr_t  wq [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle status from the timeline, writes from the queue.
    always @(negedge clk) begin
        automatic int c = cyc;
        if (c < MAXC && tl[c].valid) begin
            chk("wb_ready", 64'(wb_ready), 64'(tl[c].ready));
            chk("rf_we", 64'(rf_we), 64'(tl[c].we));
            chk("rflags_seq", rflags_seq, tl[c].flags);
            chk("rip_commit", rip_commit, tl[c].rip);
            chk("sim_done", 64'(sim_done), 64'(tl[c].done));
`ifdef WB_RETIRE_COUNT_EN
            chk("retired_count", retired_count, tl[c].cnt);
`endif
            if (tl[c].chk_ad) begin
                chk("reset_waddr", 64'(rf_waddr), 64'(tl[c].addr));
                chk("reset_wdata", rf_wdata, tl[c].data);
            end
        end
        if (rf_we === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write cycle=%0d got addr=%0d data=%h want no write",
                         c, rf_waddr, rf_wdata);
            end else begin
                automatic wr_t w = wq.pop_front();
                chk("write_cycle", 64'(c), 64'(w.cyc));
                chk("write_addr", 64'(rf_waddr), 64'(w.addr));
                chk("write_data", rf_wdata, w.data);
            end
        end
    end

    // One cycle of stimulus plus the expected consequences.
    task automatic drive(input bit rst, input bit v, input logic [7:0] op, input logic [1:0] dp,
                         input logic [3:0] rb, input logic [3:0] rm, input bit nd,
                         input logic [63:0] a, input logic [63:0] x, input logic [63:0] rp,
                         input bit fwe, input logic [63:0] fl, input bit fin);
        int c;
        exp_t cur, nx, hi;
        bit mul, sup;
        logic [3:0] d;
        @(posedge clk);
        #1;
        c = cyc;
        reset = rst; ex_valid = v; opcode = op; dep = dp; regByte = rb; rmByte = rm;
        no_dest = nd; alu_result = a; alu_ext_result = x; rip_in = rp;
        flags_we = fwe; rflags_in = fl; sim_end_in = fin;

        cur = tl[c];
        if (tl[c+1].valid) begin
            nx = tl[c+1];
        end else begin
            nx = cur;
            nx.valid = 1; nx.we = 0; nx.chk_ad = 0; nx.ready = !cur.done;
        end

        if (rst) begin
            nx.valid = 1; nx.we = 0; nx.chk_ad = 1; nx.addr = 4'd0; nx.data = 64'd0;
            nx.ready = 1; nx.flags = 64'h2; nx.rip = 64'd0; nx.done = 0; nx.cnt = 64'd0;
            tl[c+2].valid = 0;
            while (wq.size() > 0 && wq[wq.size()-1].cyc > c) void'(wq.pop_back());
        end else if (v && cur.ready) begin
            mul = (op == 8'd247);
            sup = nd || (op == 8'd116) || (op == 8'd125) || (op == 8'd141);
            d   = (op == 8'd13 || mul) ? 4'd0 : ((dp == 2'd2) ? rb : rm);
            nx.rip = rp;
            if (fwe) nx.flags = (fl | 64'h2) & ~64'h28;
            if (mul) begin
                nx.we = !nd; nx.ready = 0;
                if (!nd) wq.push_back('{cyc: c + 1, addr: 4'd0, data: a});
                hi = nx;
                hi.we = !nd; hi.ready = !fin; hi.done = fin; hi.cnt = nx.cnt + 64'd1;
                tl[c+2] = hi;
                if (!nd) wq.push_back('{cyc: c + 2, addr: 4'd2, data: x});
            end else begin
                nx.we = !sup; nx.cnt = cur.cnt + 64'd1; nx.done = fin; nx.ready = !fin;
                if (!sup) wq.push_back('{cyc: c + 1, addr: d, data: a});
            end
        end
        tl[c+1] = nx;
    endtask

    task automatic idle();
        drive(0, 0, 8'd0, 2'd0, 4'd0, 4'd0, 0, 64'd0, 64'd0, 64'd0, 0, 64'd0, 0);
    endtask

    task automatic do_reset();
        drive(1, 0, 8'd0, 2'd0, 4'd0, 4'd0, 0, 64'd0, 64'd0, 64'd0, 0, 64'd0, 0);
    endtask

    initial begin
        int halt_wait;
        bit rst, nd;
        logic [7:0] op;

        do_reset();
        do_reset();
        idle();
        // Plain write to rmByte 3.
        drive(0, 1, 8'd199, 2'd0, 4'd7, 4'd3, 0, 64'h1234, 64'd0, 64'h100, 0, 64'd0, 0);
        // IMUL: RAX then RDX, with an ignored request while busy.
        drive(0, 1, 8'd247, 2'd2, 4'd9, 4'd9, 0, 64'h5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h104, 0, 64'd0, 0);
        drive(0, 1, 8'd199, 2'd0, 4'd1, 4'd6, 0, 64'hDEAD, 64'd0, 64'h999, 1, 64'hFF, 0);
        // Flag-only compare.
        drive(0, 1, 8'd116, 2'd0, 4'd1, 4'd1, 1, 64'h77, 64'd0, 64'h108, 1, 64'h40, 0);
        // dep==2 selects regByte; opcode 13 goes to RAX; back-to-back.
        drive(0, 1, 8'd3, 2'd2, 4'd11, 4'd4, 0, 64'hA1, 64'd0, 64'h10C, 0, 64'd0, 0);
        drive(0, 1, 8'd13, 2'd2, 4'd11, 4'd4, 0, 64'hA2, 64'd0, 64'h110, 0, 64'd0, 0);
        drive(0, 1, 8'd125, 2'd0, 4'd11, 4'd4, 0, 64'hA3, 64'd0, 64'h114, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        drive(0, 1, 8'd141, 2'd0, 4'd11, 4'd8, 0, 64'hA4, 64'd0, 64'h118, 0, 64'd0, 0);
        // Reset while in HI aborts the RDX write.
        drive(0, 1, 8'd247, 2'd0, 4'd0, 4'd0, 0, 64'h11, 64'h22, 64'h11C, 0, 64'd0, 0);
        do_reset();
        idle();
        // Final instruction, then ignored requests until reset.
        drive(0, 1, 8'd1, 2'd0, 4'd2, 4'd5, 0, 64'h55, 64'd0, 64'h200, 0, 64'd0, 1);
        for (int i = 0; i < 4; i++)
            drive(0, 1, 8'd199, 2'd0, 4'd1, 4'd1, 0, 64'(i), 64'd0, 64'h300, 1, 64'h1, 0);
        do_reset();
        // Final instruction that is an IMUL.
        drive(0, 1, 8'd247, 2'd0, 4'd0, 4'd0, 0, 64'h7, 64'h8, 64'h400, 0, 64'd0, 1);
        idle(); idle(); idle();
        do_reset();

        halt_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            halt_wait = tl[cyc+1].done ? halt_wait + 1 : 0;
            rst = (halt_wait > 3) || ($urandom_range(0, 79) == 0);
            case ($urandom_range(0, 7))
                0: op = 8'd13;
                1: op = 8'd247;
                2: op = 8'd116;
                3: op = 8'd125;
                4: op = 8'd141;
                5: op = 8'd199;
                6: op = 8'd1;
                default: op = 8'($urandom_range(0, 255));
            endcase
            nd = (op != 8'd247) && ($urandom_range(0, 7) == 0);
            drive(rst, $urandom_range(0, 3) != 0, op, 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), nd,
                  {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, {$urandom, $urandom},
                  $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 4; i++) idle();

        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("FAIL missing_writes got %0d pending want 0", wq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
